// File: rtl/multiplication_seq.sv
`default_nettype none
// ============================================================================
// Module      : multiplication_seq
// Description : Iterative radix-2 shift-add multiplier for the RV32M
//               MUL / MULH / MULHSU / MULHU group. Operands are converted to
//               magnitudes on accept, multiplied unsigned over 32 RUN cycles,
//               and the sign is restored in a single FIX cycle.
//               Fixed latency: start sampled in cycle 0 gives done in cycle 34.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk     in   1      system clock, rising edge
//   rst_n   in   1      asynchronous active-low reset
//   start   in   1      request, sampled only in IDLE or DONE
//   kill    in   1      pipeline flush, abandons any operation in flight
//   Op      in   2      funct3[1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   A       in   XLEN   rs1 operand
//   B       in   XLEN   rs2 operand
//   busy    out  1      high in RUN and FIX
//   done    out  1      one-cycle completion pulse (DONE state)
//   Result  out  XLEN   selected product half, held until next completion
// ============================================================================
module multiplication_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [1:0]      Op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] Result
);

  localparam logic [1:0] c_op_mul    = 2'b00;
  localparam logic [1:0] c_op_mulh   = 2'b01;
  localparam logic [1:0] c_op_mulhsu = 2'b10;
  localparam logic [4:0] c_last_bit  = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [1:0]          r_op;
  logic [XLEN-1:0]     r_mcand;      // multiplicand magnitude (from A)
  logic [XLEN-1:0]     r_mplier;     // multiplier magnitude (from B)
  logic                r_neg;        // final product must be negated
  logic [2*XLEN-1:0]   r_acc;        // unsigned partial-product accumulator
  logic [4:0]          r_count;      // multiplier bit being processed
  logic [XLEN-1:0]     r_result;

  logic                w_accept;
  logic                w_a_signed;
  logic                w_b_signed;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [XLEN-1:0]     w_a_mag;
  logic [XLEN-1:0]     w_b_mag;
  logic [2*XLEN-1:0]   w_addend;
  logic [2*XLEN-1:0]   w_prod_fixed;

  // --------------------------------------------------------------------------
  // Operand conditioning on accept.
  // Only the signed interpretations take a magnitude; 0x80000000 negates to
  // itself, which is exactly the right magnitude when read as unsigned.
  // MUL treats both operands as unsigned: the low half of the product is the
  // same for signed and unsigned operands, so no sign handling is needed.
  // --------------------------------------------------------------------------
  always_comb begin
    w_accept   = 1'b0;
    w_a_signed = (Op == c_op_mulh) || (Op == c_op_mulhsu);
    w_b_signed = (Op == c_op_mulh);
    w_a_neg    = w_a_signed & A[XLEN-1];
    w_b_neg    = w_b_signed & B[XLEN-1];
    w_a_mag    = w_a_neg ? (~A + 1'b1) : A;
    w_b_mag    = w_b_neg ? (~B + 1'b1) : B;
    if (((r_state == IDLE) || (r_state == DONE)) && start && !kill) begin
      w_accept = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Shift-add step and sign restoration.
  // --------------------------------------------------------------------------
  always_comb begin
    w_addend     = '0;
    w_prod_fixed = r_acc;
    if (r_mplier[r_count]) begin
      w_addend = {{XLEN{1'b0}}, r_mcand} << r_count;
    end
    if (r_neg) begin
      w_prod_fixed = ~r_acc + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and outputs. kill wins over everything, including a start
  // in IDLE/DONE, and never produces a done pulse.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = RUN;
        end else begin
          w_state_next = IDLE;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (kill) begin
          w_state_next = IDLE;
        end else if (r_count == c_last_bit) begin
          w_state_next = FIX;
        end
      end
      FIX: begin
        busy = 1'b1;
        if (kill) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        // Back-to-back start goes straight to RUN with no idle bubble.
        if (w_accept) begin
          w_state_next = RUN;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= c_op_mul;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
      r_acc    <= '0;
      r_count  <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_op     <= Op;
        r_mcand  <= w_a_mag;
        r_mplier <= w_b_mag;
        r_neg    <= w_a_neg ^ w_b_neg;
        r_acc    <= '0;
        r_count  <= '0;
      end else if ((r_state == RUN) && !kill) begin
        r_acc   <= r_acc + w_addend;
        r_count <= r_count + 1'b1;
      end

      // Result only moves on the edge that enters DONE.
      if ((r_state == FIX) && !kill) begin
        if (r_op == c_op_mul) begin
          r_result <= w_prod_fixed[XLEN-1:0];
        end else begin
          r_result <= w_prod_fixed[2*XLEN-1:XLEN];
        end
      end
    end
  end

  assign Result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_multiplication_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiplication_seq
// Description : Directed and randomized checks of multiplication_seq against
//               an arithmetic reference (64-bit product of extended operands).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiplication_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        kill;
  logic [1:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] Result;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] last_result = 32'h0;

  multiplication_seq #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .kill   (kill),
    .Op     (Op),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .Result (Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: extend each operand per its signedness, take the 64-bit
  // product modulo 2^64, select the requested half.
  function automatic logic [31:0] ref_mul(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ae;
    logic [63:0] be;
    logic [63:0] p;
    ae = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'h0, a};
    be = (op == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ae * be;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Drive a request in the current cycle (cycle 0); returns in cycle 1 with
  // the operand inputs scrambled so only the latched copies can be used.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    tick();
    start = 1'b0;
    Op    = 2'($urandom);
    A     = $urandom;
    B     = $urandom;
  endtask

  // Called in cycle 1. Checks busy/done/Result in cycles 1..33 and returns in
  // cycle 34 after checking the completion. pulse_at>0 injects a stray start.
  task automatic wait_done(input string tag, input logic [31:0] exp, input int pulse_at);
    for (int c = 1; c <= 33; c++) begin
      check({tag, " busy/done"}, {30'h0, busy, done}, 32'h2);
      check({tag, " hold"}, Result, last_result);
      if (c == pulse_at) begin
        start = 1'b1;
        Op    = 2'($urandom);
        A     = $urandom;
        B     = $urandom;
      end
      if (c == pulse_at + 1) start = 1'b0;
      tick();
    end
    check({tag, " done"}, {30'h0, busy, done}, 32'h1);
    check({tag, " result"}, Result, exp);
    last_result = exp;
  endtask

  initial begin
    logic [31:0] pool [8];
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    pool[0] = 32'h0000_0000; pool[1] = 32'h0000_0001; pool[2] = 32'hFFFF_FFFF;
    pool[3] = 32'h8000_0000; pool[4] = 32'h7FFF_FFFF; pool[5] = 32'h0000_0002;
    pool[6] = 32'hFFFF_FFFE; pool[7] = 32'h8000_0001;

    rst_n = 1'b0; start = 1'b0; kill = 1'b0; Op = 2'b00; A = 32'h0; B = 32'h0;
    tick();
    tick();
    check("reset busy/done", {30'h0, busy, done}, 32'h0);
    check("reset result", Result, 32'h0);
    rst_n = 1'b1;
    tick();

    // MUL with negative B (treated unsigned, low half identical)
    launch(2'b00, 32'd7, 32'hFFFF_FFFD);
    wait_done("mul 7*-3", 32'hFFFF_FFEB, 0);
    tick();
    check("after done idle", {30'h0, busy, done}, 32'h0);
    check("after done hold", Result, 32'hFFFF_FFEB);

    launch(2'b01, 32'h8000_0000, 32'h8000_0000);
    wait_done("mulh min*min", 32'h4000_0000, 0);
    tick();
    launch(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mulhsu -1*max", 32'hFFFF_FFFF, 0);
    tick();
    launch(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mulhu max*max", 32'hFFFF_FFFE, 0);
    tick();

    // Operand change after accept, stray start in cycle 5, back-to-back start
    launch(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_done("mul latched", 32'h242D_2080, 5);
    ra = $urandom; rb = $urandom;
    launch(2'b11, ra, rb);
    wait_done("b2b mulhu", ref_mul(2'b11, ra, rb), 0);
    tick();
    check("b2b idle", {30'h0, busy, done}, 32'h0);

    // kill in cycle 10
    launch(2'b01, $urandom, $urandom);
    repeat (9) tick();
    check("pre-kill busy", {31'h0, busy}, 32'h1);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("kill idle", {30'h0, busy, done}, 32'h0);
    check("kill hold", Result, last_result);
    for (int i = 0; i < 40; i++) begin
      if (done !== 1'b0) check("kill no done", {31'h0, done}, 32'h0);
      tick();
    end
    check("kill result kept", Result, last_result);

    // kill beats start in IDLE
    start = 1'b1; kill = 1'b1; Op = 2'b11; A = 32'h5; B = 32'h5;
    tick();
    start = 1'b0; kill = 1'b0;
    check("kill+start idle", {30'h0, busy, done}, 32'h0);
    tick();

    // asynchronous reset in cycle 20
    launch(2'b10, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    repeat (19) tick();
    check("pre-reset busy", {31'h0, busy}, 32'h1);
    check("pre-reset result", Result, last_result);
    #1 rst_n = 1'b0;
    #1;
    check("async reset busy/done", {30'h0, busy, done}, 32'h0);
    check("async reset result", Result, 32'h0);
    last_result = 32'h0;
    tick();
    check("reset held", {30'h0, busy, done}, 32'h0);
    rst_n = 1'b1;
    tick();
    launch(2'b01, 32'hFFFF_FFF9, 32'h0000_0003);
    wait_done("post-reset mulh", ref_mul(2'b01, 32'hFFFF_FFF9, 32'h0000_0003), 0);
    tick();

    // randomized operations, mixing corner values and random words
    for (int n = 0; n < 24; n++) begin
      rop = 2'($urandom);
      ra  = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 7)] : $urandom;
      rb  = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 7)] : $urandom;
      launch(rop, ra, rb);
      wait_done($sformatf("rand%0d op%0d", n, rop), ref_mul(rop, ra, rb), 0);
      if ($urandom_range(0, 1) == 0) tick();
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multiplication_seq.md
# multiplication_seq

Iterative 32×32 multiplier for the RV32M MUL/MULH/MULHSU/MULHU group. It is the multiply-direction counterpart of the combinational divider in the execute stage. A radix-2 shift-add datapath gives a fixed latency of 34 cycles. A start/busy/done handshake lets the hazard unit stall the pipeline while the operation runs.

## Interface
- XLEN, 32, operand and result width; only 32 is supported.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- kill  in  1  pipeline flush; abandons the operation in progress.
- Op  in  2  funct3[1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- A, B  in  32 each  rs1 and rs2 operands.
- busy  out  1  high while an operation is in flight (RUN or FIX).
- done  out  1  one-cycle pulse; Result is valid in the same cycle.
- Result  out  32  selected product half; held until the next completion.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE, DONE with start=1 and kill=0 (accept):
  - latch Op.
  - latch |A| if A is signed (Op 01/10) and A[31]=1, else A.
  - latch |B| if B is signed (Op 01 only) and B[31]=1, else B.
  - latch neg = sign of A XOR sign of B, where an operand counts as negative only if it is signed.
  - clear the 64-bit accumulator; set count=0; go to RUN.
  - 0x80000000 magnitude is 0x80000000, taken as unsigned.
- RUN, each cycle:
  - if multiplier bit[count]=1, add (multiplicand << count) into the accumulator, using 64-bit unsigned arithmetic.
  - count++.
  - after count=31 is processed, go to FIX.
- FIX:
  - if neg, take the 64-bit two's complement of the product.
  - Result = product[31:0] for MUL, else product[63:32].
  - go to DONE.
- DONE: done=1 for this cycle. Without start, go to IDLE; with an accepted start, go to RUN.
- MUL ignores signedness: the low 32 bits must still equal the signed low product, and the neg path must preserve this.
- Operand inputs may change after accept; the latched copies are used.
- start while busy is ignored: no queueing, no error.
- kill=1 in RUN or FIX:
  - go to IDLE on the next edge.
  - no done pulse; Result unchanged.
- kill has priority over start in the same cycle.
- kill in IDLE or DONE: block goes to IDLE and start is not accepted.

## Timing
- Reset values: state=IDLE, busy=0, done=0, Result=0, count=0, accumulator=0.
- Reset asserted mid-operation: all state returns to the reset values immediately and asynchronously, with no done pulse.
- Let start be high in cycle 0:
  - busy is high in cycles 1–33 (RUN cycles 1–32, FIX cycle 33).
  - done and the new Result appear in cycle 34.
- Result is registered and changes only on the edge that enters DONE.
- Back-to-back operation: start held in cycle 34 (the DONE cycle) gives done in cycle 68, with no idle bubble.
- busy is low in the DONE cycle; the stall logic releases on done.

## Test plan
- MUL, A=7, B=0xFFFFFFFD → Result=0xFFFFFFEB; done exactly in cycle 34; busy high in cycles 1–33.
- MULH, A=B=0x80000000 → Result=0x40000000.
- MULHSU, A=0xFFFFFFFF, B=0xFFFFFFFF → Result=0xFFFFFFFF.
- MULHU, A=B=0xFFFFFFFF → Result=0xFFFFFFFE.
- MUL, A=0x12345678, B=0x9ABCDEF0:
  - A and B changed in cycle 1 → Result=0x242D2080.
  - second start pulsed in cycle 5 is ignored.
  - back-to-back start in cycle 34 gives done in cycle 68.
- kill in cycle 10 → IDLE in cycle 11, no done, Result keeps its prior value.
- rst_n low in cycle 20 → busy=0 and Result=0 immediately; a later start completes normally.
